seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring unsigned divider in the calculator datapath, downstream of the control unit.
- Started by the CU's go_div pulse; reports done_div and div_by_zero back to the CU.
- Quotient drives the low output register path and remainder the high path; the CU selects these via sel_l/sel_h.
- Produces one quotient bit per clock.

Parameters:
W  4  operand width in bits; quotient and remainder are also W bits
CW  derived, clog2(W+1)  width of the bit counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
go  in  1  start request (CU go_div); sampled on rising clk
dividend  in  W  X operand, captured on accepted go
divisor  in  W  Y operand, captured on accepted go
quotient  out  W  result quotient, registered
remainder  out  W  result remainder, registered
done  out  1  result valid (CU done_div), level
busy  out  1  high while iterating
div_by_zero  out  1  combinational (divisor == 0) on live input; the CU samples it in its load state
dz_err  out  1  registered: last accepted operation had divisor 0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; quotient, remainder, counter, internal regs = 0.
  - done=0, busy=0, dz_err=0.
- States:
  - IDLE: go=1 -> accept.
  - RUN: iterate.
  - FIN: done=1, hold results; go=1 -> accept (restart).
- Accept, on the clock edge with go=1 in IDLE or FIN:
  - Latch D=divisor; A=dividend (shift register); R=0; cnt=W.
  - Clear done and dz_err.
  - divisor != 0 -> RUN, busy=1.
  - divisor == 0 -> FIN next edge: quotient = all ones, remainder = dividend, dz_err=1, done=1. No iteration.
- RUN, each edge:
  - T = {R[W-2:0], A[W-1]} (W+1-bit compare against {0,D}).
  - T >= D: R = T - D, shift 1 into A LSB.
  - Otherwise: R = T, shift 0 into A LSB.
  - cnt decrements.
  - On the edge where cnt goes 1->0: quotient = final A, remainder = final R, busy=0, done=1, state=FIN.
- Latency:
  - Accept edge + W RUN edges; done is high in the cycle after the W-th RUN edge (W+1 edges after accept for W=4, i.e. 5).
  - Divide-by-zero path: done high 1 edge after accept.
- Handshake:
  - go is ignored while in RUN. The CU re-pulses go while polling done, and this must not restart the operation.
  - done stays high in FIN until the next accepted go, so the CU may sample it any cycle.
  - quotient and remainder are stable while done=1.
- Arithmetic:
  - Unsigned only.
  - Invariant: dividend = quotient*divisor + remainder, with remainder < divisor, for divisor != 0.
- Boundaries:
  - dividend=0 -> q=0, r=0.
  - divisor=1 -> q=dividend, r=0.
  - dividend < divisor -> q=0, r=dividend.
  - All ones / 1 -> q=all ones.
- Simultaneous events:
  - go in FIN restarts and done drops on that edge.
  - rst dominates everything.
  - rst mid-RUN aborts: outputs return to reset values immediately, no partial result.
- Divisor input changes during RUN have no effect (latched D). div_by_zero still tracks the live input.

Decomposition:
- Shared calc package:
  - W default and the state encoding (IDLE/RUN/FIN localparams).
  - DZ_QUOTIENT constant (all ones) and the F code for divide (3'b100), both shared with the CU.
- Sub-module: div_step, a combinational single restoring step. Inputs R, A MSB, D; outputs next R and q bit. It is reusable for an unrolled variant.
- Counter and FSM stay in the top module.

Test Plan:
- Reset then 13/4:
  - Pulse rst; check all outputs 0.
  - go with dividend=13, divisor=4 -> done rises exactly 5 edges after accept, quotient=3, remainder=1, dz_err=0.
- Divide by zero:
  - divisor=0 -> div_by_zero=1 combinationally before go.
  - go -> next edge done=1, quotient=15, remainder=dividend (e.g. 9), dz_err=1.
- CU-style re-pulse:
  - 15/2 with go pulsed every other cycle during RUN -> result unchanged (q=7, r=1) and latency still 5 edges.
- Restart from FIN:
  - After 6/3 (q=2, r=0) done=1, go with 7/7 -> done drops on that edge, then q=1, r=0.
- Reset mid-operation:
  - Start 14/3, assert rst after 2 RUN edges -> outputs 0 at once.
  - Subsequent 14/3 -> q=4, r=2.
- Exhaustive sweep:
  - All 256 dividend/divisor pairs for W=4.
  - Check the invariant for divisor != 0 and the dz values for divisor=0.
  - done held until the next go in every case.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared calculator constants: datapath width, divider state encoding and the
// codes the control unit uses to drive the divider.
package seq_divider_pkg;

    localparam int CALC_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CALC_W-1:0] DZ_QUOTIENT = '1;
    localparam logic [2:0]        F_DIV       = 3'b100;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] r,
    input  logic         a_msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] trial;
    logic [W:0] diff;

    assign trial = {r, a_msb};
    assign diff  = trial - {1'b0, d};

    // With r < d on entry the difference fits in W bits exactly when there is
    // no borrow, so the top bit of diff doubles as the compare result.
    assign q_bit  = ~diff[W];
    assign r_next = q_bit ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, started by
// the control unit's go_div pulse and reporting done/div-by-zero back to it.
//
// state | meaning
// IDLE  | waiting for go after reset
// RUN   | iterating, go ignored
// FIN   | result held with done=1, go restarts
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter  int W  = CALC_W,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero,
    output logic         dz_err
);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  r_reg;
    logic [W-1:0]  d_reg;
    logic [W-1:0]  r_next;
    logic          q_bit;

    assign div_by_zero = (divisor == '0);

    div_step #(.W(W)) u_step (
        .r      (r_reg),
        .a_msb  (a_reg[W-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            dz_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (go) begin
                        d_reg  <= divisor;
                        a_reg  <= dividend;
                        r_reg  <= '0;
                        cnt    <= CW'(W);
                        done   <= 1'b0;
                        dz_err <= 1'b0;
                        // Divide by zero skips iteration and reports at once.
                        if (divisor == '0) begin
                            state     <= ST_FIN;
                            quotient  <= '1;
                            remainder <= dividend;
                            dz_err    <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    a_reg <= {a_reg[W-2:0], q_bit};
                    r_reg <= r_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        quotient  <= {a_reg[W-2:0], q_bit};
                        remainder <= r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_FIN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain integer division.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor = 4'd4;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       done;
    logic       busy;
    logic       div_by_zero;
    logic       dz_err;

    int errors = 0;
    int checks = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .dz_err      (dz_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer division, with the all-ones / dividend convention for /0.
    function automatic int unsigned ref_q(input int unsigned x, input int unsigned y);
        return (y == 0) ? 15 : x / y;
    endfunction

    function automatic int unsigned ref_r(input int unsigned x, input int unsigned y);
        return (y == 0) ? x : x % y;
    endfunction

    // Issue one operation and follow it to done; optionally re-pulse go while waiting.
    task automatic run_op(input int unsigned x, input int unsigned y, input bit repulse,
                          input string tag);
        int lat;
        @(negedge clk);
        dividend = 4'(x);
        divisor  = 4'(y);
        go       = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        go = 1'b0;
        check({tag, "_busy_after_accept"}, busy, (y != 0));
        check({tag, "_done_after_accept"}, done, (y == 0));
        while (!done && lat < 20) begin
            go = repulse && (lat % 2 == 1);
            if (repulse && ($urandom_range(0, 3) == 0)) divisor = 4'($urandom_range(0, 15));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        go = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, lat, (y == 0) ? 1 : 5);
        check({tag, "_q"}, quotient, ref_q(x, y));
        check({tag, "_r"}, remainder, ref_r(x, y));
        check({tag, "_dz_err"}, dz_err, (y == 0));
        if (y != 0) check({tag, "_invariant"}, quotient * y + remainder, x);
    endtask

    task automatic hold_check(input int unsigned x, input int unsigned y, input string tag);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        dividend = 4'($urandom_range(0, 15));
        divisor  = 4'($urandom_range(0, 15));
        #1;
        check({tag, "_hold_done"}, done, 1);
        check({tag, "_hold_q"}, quotient, ref_q(x, y));
        check({tag, "_hold_r"}, remainder, ref_r(x, y));
    endtask

    initial begin
        int unsigned x, y;

        // Reset state
        #12;
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz_err", dz_err, 0);
        check("dbz_live_nonzero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(13, 4, 1'b0, "d13_4");

        // Divide by zero, div_by_zero visible before go
        @(negedge clk);
        divisor = 4'd0;
        #1;
        check("dbz_live_zero", div_by_zero, 1);
        run_op(9, 0, 1'b0, "dz9");
        hold_check(9, 0, "dz9");

        // Control unit keeps pulsing go while polling
        run_op(15, 2, 1'b1, "repulse15_2");

        // Restart from FIN
        run_op(6, 3, 1'b0, "d6_3");
        hold_check(6, 3, "d6_3");
        run_op(7, 7, 1'b0, "restart7_7");

        // Reset mid-operation
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        go       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dz_err", dz_err, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(14, 3, 1'b0, "after_rst14_3");

        // Exhaustive sweep with an idle gap to confirm done holds
        for (int i = 0; i < 256; i++) begin
            x = i / 16;
            y = i % 16;
            run_op(x, y, 1'b0, "sweep");
            hold_check(x, y, "sweep");
        end

        // Random operands, random go re-pulsing and live divisor wiggle
        for (int i = 0; i < 60; i++) begin
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            run_op(x, y, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
